execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined RISC-V core, between the ID/EX and EX/MEM pipeline registers. Computes integer ALU results and drives the EX/MEM register set consumed by the memory stage. An optional iterative multiply/divide unit implements RV32M. While it is busy, the stage stalls the upstream pipeline and injects bubbles downstream.

## Interface
- Parameters: none.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PIP_valid_i`  in  1  ID/EX holds a real instruction.
- `PIP_rs1_data_i`, `PIP_rs2_data_i`  in  32 each  forwarded register operands.
- `PIP_imm_i`  in  32  sign-extended immediate.
- `PIP_use_imm_i`  in  1  operand B = imm (1) or rs2 (0).
- `PIP_alu_op_i`  in  4  ALU operation code (package constants).
- `PIP_muldiv_i`  in  1  instruction is RV32M.
- `PIP_muldiv_op_i`  in  3  RV32M funct3.
- `PIP_rd_i`  in  5  destination register.
- `PIP_read_mem_i`, `PIP_write_mem_i`, `PIP_use_mem_i`, `PIP_write_reg_i`  in  1 each  control bits passed downstream.
- `stall_o`  out  1  freeze PC, IF/ID and ID/EX this cycle (combinational).
- `PIP_alu_result_o`  out  32  registered result; also the memory address.
- `PIP_second_operand_o`  out  32  registered rs2 data (store data).
- `PIP_rd_o`  out  5  registered destination register.
- `PIP_read_mem_o`, `PIP_write_mem_o`, `PIP_use_mem_o`, `PIP_write_reg_o`  out  1 each  registered control bits.

## Operation
- Operand A is rs1. Operand B is imm or rs2, selected by `PIP_use_imm_i`.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shifts use B[4:0]; SRA is arithmetic.
  - SLT/SLTU return 32'd0 or 32'd1.
  - Undefined codes return 0.
- Non-muldiv valid instruction: the EX/MEM registers load the result and the control bits on the next edge. Latency 1, no stall.
- `PIP_valid_i`=0: a bubble is registered (all control bits 0; data registers still load).
- Muldiv FSM, state IDLE/BUSY/DONE:
  - IDLE with valid & muldiv: capture operand magnitudes, signs and op; counter=0; go to BUSY. `stall_o`=1 and a bubble is registered.
  - BUSY: one shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle. Counter increments. After step 31, go to DONE. `stall_o`=1, bubble registered.
  - DONE: `stall_o`=0. Sign-corrected result plus the held ID/EX control bits are registered. Return to IDLE. The instruction is not restarted, even though ID/EX still holds it this cycle.
- Signed handling:
  - Operate on magnitudes.
  - MULH: negate the 64-bit product if the signs differ.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Division corner cases (RISC-V mandated):
  - Divisor 0: quotient 32'hFFFF_FFFF, remainder = dividend, for both signed and unsigned.
  - 32'h8000_0000 / -1 (signed): quotient 32'h8000_0000, remainder 0.
  - Remainder takes the sign of the dividend.

## Timing
- Reset (asynchronous, any state): FSM→IDLE, counter 0; all `PIP_*_o` registers → 0; `stall_o`=0 once IDLE.
- Muldiv latency: `stall_o` high for exactly 33 cycles (entry cycle + 32 BUSY cycles). The result appears in EX/MEM after the 34th edge counted from entry.
- Back-to-back muldiv: the second instruction enters ID/EX the cycle after DONE and starts a fresh 34-cycle sequence.
- Reset during BUSY: the partial result is discarded and no write-back is produced.
- `stall_o` is a function of state and the ID/EX inputs only, never of the EX/MEM outputs.

## Configuration
- `EX_MULDIV_EN` defined: the iterative unit and FSM are compiled in, as described above.
- `EX_MULDIV_EN` undefined:
  - No FSM; `stall_o` tied to 0.
  - Valid instructions with `PIP_muldiv_i`=1 complete in 1 cycle with result 32'd0; other control bits pass unchanged.

## Structure
- Shared package `eggcpu_pkg`:
  - ALU op codes (4-bit).
  - RV32M funct3 constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - Muldiv FSM state encoding.
- Sub-module `muldiv_unit`: FSM, counter, 64-bit accumulator, sign fix-up.
  - Handshake: start/busy/done.
  - Instantiated only under `EX_MULDIV_EN`.
- The ALU stays inline in `execute_stage`.

## Test plan
- ADD with imm: rs1=5, imm=-7 → `PIP_alu_result_o`=32'hFFFF_FFFE one edge later; `stall_o` never high.
- SRA: rs1=32'h8000_0000, rs2=4 → 32'hF800_0000. SLTU: 1 vs 32'hFFFF_FFFF → 1.
- MULH: -3 × 7 → 32'hFFFF_FFFF. MUL: same operands → 32'hFFFF_FFEB. `stall_o` high for exactly 33 cycles; `PIP_write_reg_o`=1 only on the result cycle.
- DIV: 7 / 0 → 32'hFFFF_FFFF. REM: 7 / 0 → 7. DIV: 32'h8000_0000 / -1 → 32'h8000_0000. REM: -7 / 2 → 32'hFFFF_FFFF.
- Assert `reset` at BUSY counter=10 → all outputs 0 immediately, no write-back. A following ADD completes normally in 1 cycle.
- DIVU then MUL back-to-back → two 33-cycle stalls, results in order, bubbles in between; also run with `EX_MULDIV_EN` undefined → `stall_o`=0 and result 0.

Source files
------------

// File: rtl/eggcpu_pkg.sv
// Shared definitions for the eggcpu core: ALU op codes, RV32M funct3 codes
// and the iterative mul/div FSM state encoding.
package eggcpu_pkg;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  localparam logic [2:0] MdMul    = 3'd0;
  localparam logic [2:0] MdMulh   = 3'd1;
  localparam logic [2:0] MdMulhsu = 3'd2;
  localparam logic [2:0] MdMulhu  = 3'd3;
  localparam logic [2:0] MdDiv    = 3'd4;
  localparam logic [2:0] MdDivu   = 3'd5;
  localparam logic [2:0] MdRem    = 3'd6;
  localparam logic [2:0] MdRemu   = 3'd7;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: 32 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*)
// steps on operand magnitudes, with sign fix-up applied to the held accumulator in StDone.
module muldiv_unit
  import eggcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d, rem_neg_q, rem_neg_d, div_zero_q, div_zero_d;

  logic        a_signed, b_signed, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, hi, diff;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  always_comb begin
    a_signed = op_i inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem};
    b_signed = op_i inside {MdMul, MdMulh, MdDiv, MdRem};
    sa       = a_signed & a_i[31];
    sb       = b_signed & b_i[31];
    a_mag    = sa ? -a_i : a_i;
    b_mag    = sb ? -b_i : b_i;
    sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    hi       = acc_q[63:31];
    diff     = hi - {1'b0, opnd_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StBusy;
          cnt_d      = 5'd0;
          op_d       = op_i;
          neg_d      = sa ^ sb;
          rem_neg_d  = sa;
          div_zero_d = (b_i == 32'd0);
          acc_d      = op_i[2] ? {32'd0, a_mag} : {32'd0, b_mag};
          opnd_d     = op_i[2] ? b_mag : a_mag;
        end
      end
      StBusy: begin
        if (op_q[2]) begin
          // Restoring step: shift in next dividend bit, subtract if it fits.
          if (hi >= {1'b0, opnd_q}) acc_d = {diff[31:0], acc_q[30:0], 1'b1};
          else                      acc_d = {hi[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
    rem  = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
    unique case (op_q)
      MdMul:                     result_o = prod[31:0];
      MdMulh, MdMulhsu, MdMulhu: result_o = prod[63:32];
      MdDiv, MdDivu:             result_o = quot;
      default:                   result_o = rem;
    endcase
  end

  assign busy_o = (state_q == StBusy);
  assign done_o = (state_q == StDone);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      op_q       <= 3'd0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: inline ALU feeding the EX/MEM registers. The iterative RV32M unit
// is compiled in when EX_MULDIV_EN is defined; otherwise RV32M ops complete with result 0.
module execute_stage
  import eggcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        PIP_valid_i,
  input  logic [31:0] PIP_rs1_data_i,
  input  logic [31:0] PIP_rs2_data_i,
  input  logic [31:0] PIP_imm_i,
  input  logic        PIP_use_imm_i,
  input  logic [3:0]  PIP_alu_op_i,
  input  logic        PIP_muldiv_i,
  input  logic [2:0]  PIP_muldiv_op_i,
  input  logic [4:0]  PIP_rd_i,
  input  logic        PIP_read_mem_i,
  input  logic        PIP_write_mem_i,
  input  logic        PIP_use_mem_i,
  input  logic        PIP_write_reg_i,
  output logic        stall_o,
  output logic [31:0] PIP_alu_result_o,
  output logic [31:0] PIP_second_operand_o,
  output logic [4:0]  PIP_rd_o,
  output logic        PIP_read_mem_o,
  output logic        PIP_write_mem_o,
  output logic        PIP_use_mem_o,
  output logic        PIP_write_reg_o
);

  logic [31:0] op_a, op_b, alu_result, result_d;
  logic        issue;

  assign op_a = PIP_rs1_data_i;
  assign op_b = PIP_use_imm_i ? PIP_imm_i : PIP_rs2_data_i;

  always_comb begin
    case (PIP_alu_op_i)
      AluAdd:  alu_result = op_a + op_b;
      AluSub:  alu_result = op_a - op_b;
      AluSll:  alu_result = op_a << op_b[4:0];
      AluSlt:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      AluSltu: alu_result = {31'd0, op_a < op_b};
      AluXor:  alu_result = op_a ^ op_b;
      AluSrl:  alu_result = op_a >> op_b[4:0];
      AluSra:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      AluOr:   alu_result = op_a | op_b;
      AluAnd:  alu_result = op_a & op_b;
      default: alu_result = 32'd0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic        md_busy, md_done;
  logic [31:0] md_result;

  muldiv_unit u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (PIP_valid_i & PIP_muldiv_i),
    .op_i     (PIP_muldiv_op_i),
    .a_i      (PIP_rs1_data_i),
    .b_i      (PIP_rs2_data_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // In StDone ID/EX still holds the finished op; releasing the stall retires it.
  assign stall_o  = md_busy | (PIP_valid_i & PIP_muldiv_i & ~md_done);
  assign result_d = PIP_muldiv_i ? md_result : alu_result;
`else
  logic unused_muldiv_op;
  assign unused_muldiv_op = ^PIP_muldiv_op_i;
  assign stall_o          = 1'b0;
  assign result_d         = PIP_muldiv_i ? 32'd0 : alu_result;
`endif

  assign issue = PIP_valid_i & ~stall_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PIP_alu_result_o     <= 32'd0;
      PIP_second_operand_o <= 32'd0;
      PIP_rd_o             <= 5'd0;
      PIP_read_mem_o       <= 1'b0;
      PIP_write_mem_o      <= 1'b0;
      PIP_use_mem_o        <= 1'b0;
      PIP_write_reg_o      <= 1'b0;
    end else begin
      PIP_alu_result_o     <= result_d;
      PIP_second_operand_o <= PIP_rs2_data_i;
      PIP_rd_o             <= PIP_rd_i;
      PIP_read_mem_o       <= issue & PIP_read_mem_i;
      PIP_write_mem_o      <= issue & PIP_write_mem_i;
      PIP_use_mem_o        <= issue & PIP_use_mem_i;
      PIP_write_reg_o      <= issue & PIP_write_reg_i;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage; expectations adapt to whether EX_MULDIV_EN is defined.
module tb_execute_stage;
  import eggcpu_pkg::*;

`ifdef EX_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  logic        clk, reset;
  logic        PIP_valid_i, PIP_use_imm_i, PIP_muldiv_i;
  logic [31:0] PIP_rs1_data_i, PIP_rs2_data_i, PIP_imm_i;
  logic [3:0]  PIP_alu_op_i;
  logic [2:0]  PIP_muldiv_op_i;
  logic [4:0]  PIP_rd_i;
  logic        PIP_read_mem_i, PIP_write_mem_i, PIP_use_mem_i, PIP_write_reg_i;
  logic        stall_o;
  logic [31:0] PIP_alu_result_o, PIP_second_operand_o;
  logic [4:0]  PIP_rd_o;
  logic        PIP_read_mem_o, PIP_write_mem_o, PIP_use_mem_o, PIP_write_reg_o;

  execute_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .PIP_valid_i          (PIP_valid_i),
    .PIP_rs1_data_i       (PIP_rs1_data_i),
    .PIP_rs2_data_i       (PIP_rs2_data_i),
    .PIP_imm_i            (PIP_imm_i),
    .PIP_use_imm_i        (PIP_use_imm_i),
    .PIP_alu_op_i         (PIP_alu_op_i),
    .PIP_muldiv_i         (PIP_muldiv_i),
    .PIP_muldiv_op_i      (PIP_muldiv_op_i),
    .PIP_rd_i             (PIP_rd_i),
    .PIP_read_mem_i       (PIP_read_mem_i),
    .PIP_write_mem_i      (PIP_write_mem_i),
    .PIP_use_mem_i        (PIP_use_mem_i),
    .PIP_write_reg_i      (PIP_write_reg_i),
    .stall_o              (stall_o),
    .PIP_alu_result_o     (PIP_alu_result_o),
    .PIP_second_operand_o (PIP_second_operand_o),
    .PIP_rd_o             (PIP_rd_o),
    .PIP_read_mem_o       (PIP_read_mem_o),
    .PIP_write_mem_o      (PIP_write_mem_o),
    .PIP_use_mem_o        (PIP_use_mem_o),
    .PIP_write_reg_o      (PIP_write_reg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: any registered control bit means a write-back the scoreboard must account for.
  always @(negedge clk) begin
    logic [3:0] ctrl;
    exp_t e;
    ctrl = {PIP_read_mem_o, PIP_write_mem_o, PIP_use_mem_o, PIP_write_reg_o};
    if (!reset && ctrl != 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ctrl=%b rd=%0d res=%h expected no output",
                 ctrl, PIP_rd_o, PIP_alu_result_o);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, PIP_alu_result_o, e.res);
        check({e.name, "_op2"}, PIP_second_operand_o, e.op2);
        check({e.name, "_rd"}, {27'd0, PIP_rd_o}, {27'd0, e.rd});
        check({e.name, "_ctrl"}, {28'd0, ctrl}, {28'd0, e.ctrl});
      end
    end
  end

  task automatic drive(input logic [3:0] alu_op, input logic md, input logic [2:0] md_op,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic use_imm, input logic [4:0] rd, input logic [3:0] ctrl);
    PIP_valid_i     = 1'b1;
    PIP_alu_op_i    = alu_op;
    PIP_muldiv_i    = md;
    PIP_muldiv_op_i = md_op;
    PIP_rs1_data_i  = rs1;
    PIP_rs2_data_i  = rs2;
    PIP_imm_i       = imm;
    PIP_use_imm_i   = use_imm;
    PIP_rd_i        = rd;
    {PIP_read_mem_i, PIP_write_mem_i, PIP_use_mem_i, PIP_write_reg_i} = ctrl;
  endtask

  // Issue one instruction, count its stall cycles, and hand its result to the scoreboard.
  task automatic issue(input string name, input logic [3:0] alu_op, input logic md,
                       input logic [2:0] md_op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                       input logic [3:0] ctrl, input logic [31:0] exp_res);
    int   n = 0;
    exp_t e;
    drive(alu_op, md, md_op, rs1, rs2, imm, use_imm, rd, ctrl);
    e.name = name; e.res = exp_res; e.op2 = rs2; e.rd = rd; e.ctrl = ctrl;
    if (ctrl != 4'b0) exp_q.push_back(e);
    @(negedge clk);
    while (stall_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, n, (md && MdEn) ? 32'd33 : 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input int cycles);
    PIP_valid_i     = 1'b0;
    PIP_write_reg_i = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] md_exp(input logic [31:0] v);
    return MdEn ? v : 32'd0;
  endfunction

  initial begin
    int   wait_n;
    exp_t e;
    reset = 1'b1;
    drive(AluAdd, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0);
    PIP_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", PIP_alu_result_o, 32'd0);
    check("reset_ctrl", {28'd0, PIP_read_mem_o, PIP_write_mem_o, PIP_use_mem_o,
                         PIP_write_reg_o}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    reset = 1'b0;

    issue("add_imm", AluAdd, 1'b0, 3'd0, 32'd5, 32'd0, 32'hFFFF_FFF9, 1'b1, 5'd1, 4'b0001,
          32'hFFFF_FFFE);
    issue("sub", AluSub, 1'b0, 3'd0, 32'd10, 32'd3, 32'd0, 1'b0, 5'd2, 4'b0001, 32'd7);
    issue("sra", AluSra, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd3, 4'b0001,
          32'hF800_0000);
    issue("srl", AluSrl, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd4, 4'b0001,
          32'h0800_0000);
    issue("sltu", AluSltu, 1'b0, 3'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5, 4'b0001, 32'd1);
    issue("slt", AluSlt, 1'b0, 3'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6, 4'b0001, 32'd0);
    issue("sll_b40", AluSll, 1'b0, 3'd0, 32'd1, 32'h0000_003F, 32'd0, 1'b0, 5'd7, 4'b0001,
          32'h8000_0000);
    issue("xor", AluXor, 1'b0, 3'd0, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd8, 4'b0001, 32'h0FF0);
    issue("or", AluOr, 1'b0, 3'd0, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd9, 4'b0001, 32'hFFF0);
    issue("and", AluAnd, 1'b0, 3'd0, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd10, 4'b0001, 32'hF000);
    issue("undef_op", 4'hF, 1'b0, 3'd0, 32'h1234, 32'h5678, 32'd0, 1'b0, 5'd11, 4'b0001, 32'd0);
    issue("store", AluAdd, 1'b0, 3'd0, 32'h100, 32'hDEAD_BEEF, 32'd8, 1'b1, 5'd0, 4'b0110,
          32'h108);
    bubble(3);

    issue("mulh", AluAdd, 1'b1, MdMulh, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 5'd12, 4'b0001,
          md_exp(32'hFFFF_FFFF));
    bubble(2);
    issue("mul", AluAdd, 1'b1, MdMul, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 5'd13, 4'b0001,
          md_exp(32'hFFFF_FFEB));
    issue("mulhu", AluAdd, 1'b1, MdMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd14,
          4'b0001, md_exp(32'hFFFF_FFFE));
    issue("mulhsu", AluAdd, 1'b1, MdMulhsu, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd15, 4'b0001,
          md_exp(32'hFFFF_FFFF));
    issue("div_by0", AluAdd, 1'b1, MdDiv, 32'd7, 32'd0, 32'd0, 1'b0, 5'd16, 4'b0001,
          md_exp(32'hFFFF_FFFF));
    issue("rem_by0", AluAdd, 1'b1, MdRem, 32'd7, 32'd0, 32'd0, 1'b0, 5'd17, 4'b0001,
          md_exp(32'd7));
    issue("div_ovf", AluAdd, 1'b1, MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd18,
          4'b0001, md_exp(32'h8000_0000));
    issue("rem_ovf", AluAdd, 1'b1, MdRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd19,
          4'b0001, md_exp(32'd0));
    issue("rem_neg", AluAdd, 1'b1, MdRem, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 5'd20, 4'b0001,
          md_exp(32'hFFFF_FFFF));
    issue("div_neg", AluAdd, 1'b1, MdDiv, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 5'd21, 4'b0001,
          md_exp(32'hFFFF_FFFD));
    issue("remu", AluAdd, 1'b1, MdRemu, 32'd100, 32'd7, 32'd0, 1'b0, 5'd22, 4'b0001,
          md_exp(32'd2));
    // Back-to-back DIVU then MUL.
    issue("divu_b2b", AluAdd, 1'b1, MdDivu, 32'd100, 32'd7, 32'd0, 1'b0, 5'd23, 4'b0001,
          md_exp(32'd14));
    issue("mul_b2b", AluAdd, 1'b1, MdMul, 32'd6, 32'd7, 32'd0, 1'b0, 5'd24, 4'b0001,
          md_exp(32'd42));
    bubble(2);

    // Reset mid-division: no write-back may appear afterwards.
    drive(AluAdd, 1'b1, MdDiv, 32'd7, 32'd3, 32'd0, 1'b0, 5'd25, 4'b0001);
    if (!MdEn) begin
      e.name = "div_pre_reset"; e.res = 32'd0; e.op2 = 32'd3; e.rd = 5'd25; e.ctrl = 4'b0001;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!MdEn) PIP_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stall_busy_cnt10", {31'd0, stall_o}, {31'd0, MdEn});
    PIP_valid_i = 1'b0;
    reset       = 1'b1;
    #1;
    check("midreset_result", PIP_alu_result_o, 32'd0);
    check("midreset_op2", PIP_second_operand_o, 32'd0);
    check("midreset_rd", {27'd0, PIP_rd_o}, 32'd0);
    check("midreset_ctrl", {28'd0, PIP_read_mem_o, PIP_write_mem_o, PIP_use_mem_o,
                            PIP_write_reg_o}, 32'd0);
    check("midreset_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue("add_after_reset", AluAdd, 1'b0, 3'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd26, 4'b0001,
          32'd5);
    bubble(40);

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
